// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch unit: FSM state encoding and the
// NOP word presented to the decoder outside EXEC.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC selection for the fetch unit: increment, absolute load or
// relative (two's-complement offset) load, all modulo 2^PC_WIDTH.
module pc_next_calc #(
  parameter int PC_WIDTH = 8
) (
  input  logic [PC_WIDTH-1:0] pc_i,
  input  logic                load_i,
  input  logic                rel_i,
  input  logic [PC_WIDTH-1:0] literal_i,
  output logic [PC_WIDTH-1:0] pc_next_o
);

  // Offset and PC share a width, so a plain modular add equals adding the
  // sign-extended offset and wraps correctly in both directions.
  always_comb begin
    pc_next_o = pc_i + PC_WIDTH'(1);
    if (load_i) begin
      pc_next_o = rel_i ? (pc_i + literal_i) : literal_i;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC sequencer with PC update at EXEC exit.
// Optional macro FETCH_INSTR_COUNT_EN adds a 16-bit EXEC-cycle counter output.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_WIDTH          = 8,
  parameter int PROGRAM_DataWidth = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         stall,
  input  logic                         cnt_wr_en,
  input  logic                         add_offset,
  input  logic [PC_WIDTH-1:0]          literal_adr,
  output logic                         imem_req,
  output logic [PC_WIDTH-1:0]          imem_addr,
  input  logic                         imem_ack,
  input  logic [PROGRAM_DataWidth-1:0] imem_data,
  output logic [PROGRAM_DataWidth-1:0] instruction,
  output logic                         instr_valid,
`ifdef FETCH_INSTR_COUNT_EN
  output logic [15:0]                  instr_count,
`endif
  output logic [PC_WIDTH-1:0]          pc
);

  state_e                         state_q, state_d;
  logic [PC_WIDTH-1:0]            pc_q, pc_d, pc_next;
  logic [PROGRAM_DataWidth-1:0]   instr_q, instr_d;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next_calc (
    .pc_i      (pc_q),
    .load_i    (cnt_wr_en),
    .rel_i     (add_offset),
    .literal_i (literal_adr),
    .pc_next_o (pc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!stall) state_d = ST_FETCH;
      ST_FETCH: if (imem_ack) state_d = ST_EXEC;
      ST_EXEC:  state_d = stall ? ST_IDLE : ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs are pure functions of state so reset drops them without a clock.
  always_comb begin
    imem_req    = (state_q == ST_FETCH);
    instr_valid = (state_q == ST_EXEC);
    instruction = (state_q == ST_EXEC) ? instr_q : PROGRAM_DataWidth'(NOP_INSTR);
  end

  // Decoder load inputs and memory ack are only honoured in their own state.
  always_comb begin
    pc_d    = (state_q == ST_EXEC) ? pc_next : pc_q;
    instr_d = (state_q == ST_FETCH && imem_ack) ? imem_data : instr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign pc        = pc_q;
  assign imem_addr = pc_q;

`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] count_q, count_d;

  always_comb begin
    count_d = (state_q == ST_EXEC) ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign instr_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard testbench for fetch_unit: expected {pc, instruction} pairs are
// queued at ack time and checked by a monitor whenever instr_valid is high.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        cnt_wr_en;
  logic        add_offset;
  logic [7:0]  literal_adr;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc;
`ifdef FETCH_INSTR_COUNT_EN
  logic [15:0] instr_count;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];

  fetch_unit #(.PC_WIDTH(8), .PROGRAM_DataWidth(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .cnt_wr_en   (cnt_wr_en),
    .add_offset  (add_offset),
    .literal_adr (literal_adr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .instruction (instruction),
    .instr_valid (instr_valid),
`ifdef FETCH_INSTR_COUNT_EN
    .instr_count (instr_count),
`endif
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every EXEC cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && instr_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("exec_unexpected", 32'd1, 32'd0);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("exec_pc", {24'd0, pc}, {24'd0, e[23:16]});
        chk("exec_instr", {16'd0, instruction}, {16'd0, e[15:0]});
        chk("exec_req_low", {31'd0, imem_req}, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full instruction: wait for FETCH at exp_pc, ack after 'delay' cycles,
  // then drive the decoder load inputs during EXEC.
  task automatic fetch_one(input logic [7:0] exp_pc, input int delay,
                           input logic wr, input logic add, input logic [7:0] lit,
                           input logic stray, input logic stall_mid);
    int n;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("fetch_timeout", {31'd0, imem_req}, 32'd1);
    chk("fetch_addr", {24'd0, imem_addr}, {24'd0, exp_pc});
    for (int d = 0; d < delay; d++) begin
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_nop", {16'd0, instruction}, 32'd0);
      if (stall_mid && d == 0) stall = 1'b1;
      step();
    end
    exp_q.push_back({exp_pc, 8'hA5, exp_pc});
    imem_ack  = 1'b1;
    imem_data = {8'hA5, exp_pc};
    step();
    imem_ack    = stray;
    imem_data   = 16'hDEAD;
    cnt_wr_en   = wr;
    add_offset  = add;
    literal_adr = lit;
    step();
    imem_ack    = 1'b0;
    cnt_wr_en   = 1'b0;
    add_offset  = 1'b0;
    literal_adr = 8'h00;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; cnt_wr_en = 1'b0; add_offset = 1'b0;
    literal_adr = 8'h00; imem_ack = 1'b0; imem_data = 16'h0000;
    step();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_instr", {16'd0, instruction}, 32'd0);
    chk("rst_pc", {24'd0, pc}, 32'd0);
    step();
    rst_n = 1'b1;

    // Sequential fetch with immediate acks, then absolute/relative loads.
    fetch_one(8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    fetch_one(8'h01, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    fetch_one(8'h02, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    fetch_one(8'h03, 0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    fetch_one(8'h10, 0, 1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    fetch_one(8'h42, 0, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
    fetch_one(8'h10, 0, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    fetch_one(8'h0E, 0, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
    fetch_one(8'hFF, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    // Slow memory with a stray ack during EXEC.
    fetch_one(8'h00, 5, 1'b1, 1'b0, 8'h20, 1'b1, 1'b0);
    // Stall raised mid-fetch: fetch completes, then the FSM parks in IDLE.
    fetch_one(8'h20, 2, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("stall_idle_req", {31'd0, imem_req}, 32'd0);
      chk("stall_idle_valid", {31'd0, instr_valid}, 32'd0);
      step();
    end
    chk("stall_pc", {24'd0, pc}, 32'h21);
    stall = 1'b0;
    fetch_one(8'h21, 0, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
    fetch_one(8'hF0, 1, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0);

    // Asynchronous reset in the middle of an outstanding fetch at 0x10.
    while (imem_req !== 1'b1) step();
    chk("pre_rst_addr", {24'd0, imem_addr}, 32'h10);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", {24'd0, pc}, 32'd0);
`ifdef FETCH_INSTR_COUNT_EN
    chk("rst_count", {16'd0, instr_count}, 32'd0);
`endif
    step();
    imem_ack  = 1'b1;
    imem_data = 16'hBEEF;
    rst_n     = 1'b1;
    step();
    imem_ack  = 1'b0;
    chk("late_ack_no_exec", {31'd0, instr_valid}, 32'd0);
    fetch_one(8'h00, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    fetch_one(8'h01, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    fetch_one(8'h02, 0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
`ifdef FETCH_INSTR_COUNT_EN
    chk("count_three", {16'd0, instr_count}, 32'd3);
`endif
    step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
